// File: rtl/irq_pkg.sv
// Shared constants for the interrupt arbiter: handshake FSM encoding and the
// default vector table layout.
package irq_pkg;

    typedef logic [1:0] irq_state_t;

    localparam irq_state_t IRQ_IDLE    = 2'b00;
    localparam irq_state_t IRQ_REQ     = 2'b01;
    localparam irq_state_t IRQ_ACK     = 2'b10;
    localparam irq_state_t IRQ_SERVICE = 2'b11;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam int unsigned VEC_STRIDE_DEF = 32'd4;

endpackage

// File: rtl/irq_arbiter_if.sv
// Peripheral/core-facing signal bundle of the interrupt arbiter. The master
// side drives sources and core handshakes; the slave side is the arbiter.
interface irq_arbiter_if #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter int ADDR_W  = 32
) ();

    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_en;
    logic               irq_status_update;
    logic               irq_context;
    logic               irq_ack_core;
    logic               irq;
    logic               irq_status;
    logic [IDX_W-1:0]   irq_id;
    logic [ADDR_W-1:0]  irq_vector;
    logic [NUM_IRQ-1:0] src_ack;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output irq_src, irq_en, irq_status_update, irq_context, irq_ack_core,
        input  irq, irq_status, irq_id, irq_vector, src_ack, pending
    );

    modport slave (
        input  irq_src, irq_en, irq_status_update, irq_context, irq_ack_core,
        output irq, irq_status, irq_id, irq_vector, src_ack, pending
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            idx = req[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt front-end: per-source pending capture, fixed-priority selection
// and the core take/ack/mret handshake, with fully registered outputs.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int                  NUM_IRQ    = 4,
    parameter int                  IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter int                  ADDR_W     = 32,
    parameter logic [NUM_IRQ-1:0]  EDGE_MASK  = {NUM_IRQ{1'b0}},
    parameter logic [31:0]         VEC_BASE   = VEC_BASE_DEF,
    parameter int unsigned         VEC_STRIDE = VEC_STRIDE_DEF
) (
    input logic         CLK,
    input logic         RES_N,
    irq_arbiter_if.slave bus
);

    irq_state_t         state_q, state_d;
    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic               irq_q, irq_d;
    logic               irq_status_q, irq_status_d;
    logic [IDX_W-1:0]   irq_id_q, irq_id_d;
    logic [ADDR_W-1:0]  irq_vector_q, irq_vector_d;
    logic [NUM_IRQ-1:0] src_ack_q, src_ack_d;

    logic [NUM_IRQ-1:0] cand_s;
    logic               win_valid_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [NUM_IRQ-1:0] id_onehot_s;
    logic               cur_cand_s;
    logic               ack_fire_s;

    assign cand_s = pending_q & bus.irq_en;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req   (cand_s),
        .valid (win_valid_s),
        .idx   (win_idx_s)
    );

    // Decode the latched winner index into a one-hot select.
    always_comb begin
        id_onehot_s = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            id_onehot_s[i] = (irq_id_q == IDX_W'(i));
        end
    end

    assign cur_cand_s = |(cand_s & id_onehot_s);

    // Handshake FSM; the winner is latched only on leaving IDLE, so later
    // higher-priority arrivals never preempt a presented request.
    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        irq_vector_d = irq_vector_q;
        ack_fire_s   = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (win_valid_s) begin
                    irq_id_d     = win_idx_s;
                    irq_vector_d = ADDR_W'(VEC_BASE)
                                 + ADDR_W'(win_idx_s) * ADDR_W'(VEC_STRIDE);
                    state_d      = IRQ_REQ;
                end else begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_REQ: begin
                if (bus.irq_status_update && bus.irq_context) begin
                    state_d = IRQ_ACK;
                end else if (!cur_cand_s) begin
                    state_d = IRQ_IDLE;
                end else begin
                    state_d = IRQ_REQ;
                end
            end
            IRQ_ACK: begin
                if (bus.irq_ack_core) begin
                    ack_fire_s = 1'b1;
                    state_d    = IRQ_SERVICE;
                end else begin
                    state_d = IRQ_ACK;
                end
            end
            IRQ_SERVICE: begin
                if (bus.irq_status_update && !bus.irq_context) begin
                    state_d = IRQ_IDLE;
                end else begin
                    state_d = IRQ_SERVICE;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    // Pending capture: an edge arriving with the clear wins over the clear.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                pending_d[i] = (bus.irq_src[i] & ~src_q[i])
                             | (pending_q[i] & ~(ack_fire_s & id_onehot_s[i]));
            end else begin
                pending_d[i] = bus.irq_src[i];
            end
        end
    end

    // Moore outputs derived from the next state.
    always_comb begin
        irq_d        = (state_d == IRQ_REQ);
        irq_status_d = (state_d == IRQ_ACK) || (state_d == IRQ_SERVICE);
        src_ack_d    = ack_fire_s ? id_onehot_s : {NUM_IRQ{1'b0}};
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q      <= IRQ_IDLE;
            src_q        <= '0;
            pending_q    <= '0;
            irq_q        <= 1'b0;
            irq_status_q <= 1'b0;
            irq_id_q     <= '0;
            irq_vector_q <= '0;
            src_ack_q    <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= bus.irq_src;
            pending_q    <= pending_d;
            irq_q        <= irq_d;
            irq_status_q <= irq_status_d;
            irq_id_q     <= irq_id_d;
            irq_vector_q <= irq_vector_d;
            src_ack_q    <= src_ack_d;
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_status = irq_status_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.irq_vector = irq_vector_q;
    assign bus.src_ack    = src_ack_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: four sources, source 2 edge-mode, the rest
// level-mode, vectors at 0x100 + 4*id.
module tb_irq_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 32;

    logic CLK   = 1'b0;
    logic RES_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    irq_arbiter_if #(.NUM_IRQ(N), .IDX_W(IW), .ADDR_W(AW)) bus ();

    irq_arbiter #(
        .NUM_IRQ    (N),
        .ADDR_W     (AW),
        .EDGE_MASK  (4'b0100),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (4)
    ) dut (
        .CLK   (CLK),
        .RES_N (RES_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic ctx);
        bus.irq_status_update = 1'b1;
        bus.irq_context       = ctx;
        step();
        bus.irq_status_update = 1'b0;
        bus.irq_context       = 1'b0;
    endtask

    task automatic ack();
        bus.irq_ack_core = 1'b1;
        step();
        bus.irq_ack_core = 1'b0;
    endtask

    task automatic test_reset();
        bus.irq_src = 4'b0000; bus.irq_en = 4'b1111;
        bus.irq_status_update = 1'b0; bus.irq_context = 1'b0; bus.irq_ack_core = 1'b0;
        RES_N = 1'b0;
        #23;
        checks++;
        if ({bus.irq, bus.irq_status, bus.irq_id, bus.irq_vector, bus.src_ack, bus.pending} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs got irq=%b st=%b id=%0d vec=%h ack=%b pend=%b exp all zero",
                     bus.irq, bus.irq_status, bus.irq_id, bus.irq_vector, bus.src_ack, bus.pending);
        end
        step();
        RES_N = 1'b1;
        step();
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_idle_irq got %b exp 0", bus.irq); end
    endtask

    task automatic test_edge_basic();
        bus.irq_src[2] = 1'b1;
        step();
        checks++;
        if (bus.pending !== 4'b0100) begin errors++; $display("FAIL edge_pending got %b exp 0100", bus.pending); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early got %b exp 0", bus.irq); end
        step();
        checks++;
        if ({bus.irq, bus.irq_id, bus.irq_vector} !== {1'b1, 2'd2, 32'h0000_0108}) begin
            errors++;
            $display("FAIL edge_present got irq=%b id=%0d vec=%h exp irq=1 id=2 vec=00000108",
                     bus.irq, bus.irq_id, bus.irq_vector);
        end
        upd(1'b1);
        checks++;
        if ({bus.irq, bus.irq_status} !== 2'b01) begin
            errors++; $display("FAIL edge_take got irq=%b st=%b exp irq=0 st=1", bus.irq, bus.irq_status);
        end
        ack();
        checks++;
        if ({bus.src_ack, bus.pending} !== 8'b0100_0000) begin
            errors++; $display("FAIL edge_ack got ack=%b pend=%b exp ack=0100 pend=0000", bus.src_ack, bus.pending);
        end
        step();
        checks++;
        if (bus.src_ack !== 4'b0000) begin errors++; $display("FAIL edge_ack_width got %b exp 0000", bus.src_ack); end
        upd(1'b0);
        checks++;
        if (bus.irq_status !== 1'b0) begin errors++; $display("FAIL edge_mret got %b exp 0", bus.irq_status); end
        bus.irq_src[2] = 1'b0;
        step();
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL edge_no_repeat got %b exp 0", bus.irq); end
    endtask

    task automatic test_priority();
        bus.irq_src[1] = 1'b1; bus.irq_src[3] = 1'b1;
        step();
        checks++;
        if (bus.pending !== 4'b1010) begin errors++; $display("FAIL prio_pending got %b exp 1010", bus.pending); end
        step();
        checks++;
        if ({bus.irq, bus.irq_id, bus.irq_vector} !== {1'b1, 2'd1, 32'h0000_0104}) begin
            errors++;
            $display("FAIL prio_first got irq=%b id=%0d vec=%h exp irq=1 id=1 vec=00000104",
                     bus.irq, bus.irq_id, bus.irq_vector);
        end
        upd(1'b1);
        ack();
        checks++;
        if ({bus.src_ack, bus.pending} !== 8'b0010_1010) begin
            errors++; $display("FAIL prio_ack got ack=%b pend=%b exp ack=0010 pend=1010", bus.src_ack, bus.pending);
        end
        bus.irq_src[1] = 1'b0;
        step();
        upd(1'b0);
        step();
        checks++;
        if ({bus.irq, bus.irq_id, bus.irq_vector} !== {1'b1, 2'd3, 32'h0000_010C}) begin
            errors++;
            $display("FAIL prio_second got irq=%b id=%0d vec=%h exp irq=1 id=3 vec=0000010c",
                     bus.irq, bus.irq_id, bus.irq_vector);
        end
        upd(1'b1);
        ack();
        checks++;
        if (bus.src_ack !== 4'b1000) begin errors++; $display("FAIL prio_ack3 got %b exp 1000", bus.src_ack); end
        bus.irq_src[3] = 1'b0;
        step();
        upd(1'b0);
        step();
    endtask

    task automatic test_withdraw();
        bus.irq_src[0] = 1'b1;
        step();
        step();
        checks++;
        if ({bus.irq, bus.irq_id} !== {1'b1, 2'd0}) begin
            errors++; $display("FAIL wd_present got irq=%b id=%0d exp irq=1 id=0", bus.irq, bus.irq_id);
        end
        bus.irq_src[0] = 1'b0;
        step();
        checks++;
        if (bus.pending !== 4'b0000) begin errors++; $display("FAIL wd_pending got %b exp 0000", bus.pending); end
        step();
        checks++;
        if ({bus.irq, bus.irq_status, bus.src_ack} !== 6'b0) begin
            errors++; $display("FAIL wd_drop got irq=%b st=%b ack=%b exp all 0", bus.irq, bus.irq_status, bus.src_ack);
        end
        upd(1'b1);
        checks++;
        if (bus.irq_status !== 1'b0) begin errors++; $display("FAIL wd_idle_ignore got %b exp 0", bus.irq_status); end
    endtask

    task automatic test_mask();
        bus.irq_en = 4'b1011;
        bus.irq_src[2] = 1'b1;
        step();
        bus.irq_src[2] = 1'b0;
        step();
        step();
        checks++;
        if ({bus.irq, bus.pending} !== 5'b0_0100) begin
            errors++; $display("FAIL mask_hold got irq=%b pend=%b exp irq=0 pend=0100", bus.irq, bus.pending);
        end
        bus.irq_en = 4'b1111;
        step();
        checks++;
        if ({bus.irq, bus.irq_id} !== {1'b1, 2'd2}) begin
            errors++; $display("FAIL mask_unmask got irq=%b id=%0d exp irq=1 id=2", bus.irq, bus.irq_id);
        end
        upd(1'b1);
        ack();
        checks++;
        if (bus.pending !== 4'b0000) begin errors++; $display("FAIL mask_clear got %b exp 0000", bus.pending); end
        upd(1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        bus.irq_src[2] = 1'b1;
        step();
        bus.irq_src[2] = 1'b0;
        step();
        upd(1'b1);
        bus.irq_ack_core = 1'b1;
        bus.irq_src[2]   = 1'b1;
        step();
        bus.irq_ack_core = 1'b0;
        bus.irq_src[2]   = 1'b0;
        checks++;
        if ({bus.src_ack, bus.pending} !== 8'b0100_0100) begin
            errors++; $display("FAIL b2b_set_wins got ack=%b pend=%b exp ack=0100 pend=0100", bus.src_ack, bus.pending);
        end
        step();
        upd(1'b0);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got %b exp 0", bus.irq); end
        step();
        checks++;
        if ({bus.irq, bus.irq_id, bus.irq_vector} !== {1'b1, 2'd2, 32'h0000_0108}) begin
            errors++;
            $display("FAIL b2b_represent got irq=%b id=%0d vec=%h exp irq=1 id=2 vec=00000108",
                     bus.irq, bus.irq_id, bus.irq_vector);
        end
        upd(1'b1);
        ack();
        checks++;
        if (bus.pending !== 4'b0000) begin errors++; $display("FAIL b2b_clear got %b exp 0000", bus.pending); end
        upd(1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        bus.irq_src[2] = 1'b1;
        step();
        step();
        upd(1'b1);
        ack();
        #2;
        RES_N = 1'b0;
        #1;
        checks++;
        if ({bus.irq, bus.irq_status, bus.irq_id, bus.irq_vector, bus.src_ack, bus.pending} !== 45'd0) begin
            errors++;
            $display("FAIL rst_mid got irq=%b st=%b id=%0d vec=%h ack=%b pend=%b exp all zero",
                     bus.irq, bus.irq_status, bus.irq_id, bus.irq_vector, bus.src_ack, bus.pending);
        end
        step();
        RES_N = 1'b1;
        step();
        checks++;
        if (bus.pending !== 4'b0100) begin errors++; $display("FAIL rst_edge_event got %b exp 0100", bus.pending); end
        step();
        checks++;
        if ({bus.irq, bus.irq_id} !== {1'b1, 2'd2}) begin
            errors++; $display("FAIL rst_present got irq=%b id=%0d exp irq=1 id=2", bus.irq, bus.irq_id);
        end
        upd(1'b1);
        ack();
        step();
        checks++;
        if (bus.pending !== 4'b0000) begin errors++; $display("FAIL rst_single_event got %b exp 0000", bus.pending); end
        upd(1'b0);
        step();
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_final_idle got %b exp 0", bus.irq); end
        bus.irq_src[2] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_priority();
        test_withdraw();
        test_mask();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
